// File: rtl/com_rx_frontend.sv
// -----------------------------------------------------------------------------
// com_rx_frontend
//
// Receive front end of the MCU-to-draw communication path. The asynchronous,
// bouncy MCU go strobe is synchronized and debounced into a single-cycle write
// pulse. Each pulse pushes the 10-bit word {iCmd, iD} into a show-ahead FIFO.
// The FIFO head word is presented together with a one-hot decode of its low
// command nibble for the downstream command controller.
//
// Ports:
//   iClk            in   1       system clock, rising edge
//   iRst            in   1       asynchronous, active-high reset
//   iD              in   9       MCU data, held stable while iGo is high
//   iCmd            in   1       MCU command flag, stored as bit 9
//   iGo             in   1       MCU go strobe (asynchronous, bouncy)
//   iPop            in   1       read request, consumes the head word
//   oQ              out  10      head word {cmd, data}, zero while empty
//   oCmd            out  1       oQ[9]
//   oEq             out  16      one-hot decode of oQ[3:0], zero while empty
//   oEmpty          out  1       FIFO empty
//   oFull           out  1       FIFO full
//   oFullPersistent out  1       sticky full flag, cleared only by reset
//   oUsed           out  ADDR_W  word count modulo 2**ADDR_W (0 when full)
//   oWrPulse        out  1       debounced go pulse, the FIFO write strobe
// -----------------------------------------------------------------------------
module com_rx_frontend #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ADDR_W          = 10
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [8:0]        iD,
    input  logic              iCmd,
    input  logic              iGo,
    input  logic              iPop,
    output logic [9:0]        oQ,
    output logic              oCmd,
    output logic [15:0]       oEq,
    output logic              oEmpty,
    output logic              oFull,
    output logic              oFullPersistent,
    output logic [ADDR_W-1:0] oUsed,
    output logic              oWrPulse
);

    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam logic [15:0]       DEB_TARGET = 16'(DEBOUNCE_CYCLES);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    // ------------------------------------------------------------------
    // Debounce: two-flop synchronizer, mismatch counter, stable level and
    // a delayed copy of the stable level for rising-edge detection.
    // ------------------------------------------------------------------
    logic        go_meta_q,    go_meta_d;
    logic        go_sync_q,    go_sync_d;
    logic [15:0] deb_cnt_q,    deb_cnt_d;
    logic        stable_q,     stable_d;
    logic        stable_dly_q, stable_dly_d;
    logic        wr_pulse_q,   wr_pulse_d;

    // NOTE: every always_comb output gets a default assignment first so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        go_meta_d    = iGo;
        go_sync_d    = go_meta_q;
        deb_cnt_d    = deb_cnt_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;

        if (go_sync_q == stable_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_TARGET) begin
            // Synchronized level has disagreed for long enough: accept it.
            stable_d  = go_sync_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 16'd1;
        end

        // Pulse in the cycle after the stable level rises; falls are ignored.
        wr_pulse_d = stable_q & ~stable_dly_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours regardless of order.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            go_meta_q    <= 1'b0;
            go_sync_q    <= 1'b0;
            deb_cnt_q    <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            wr_pulse_q   <= 1'b0;
        end else begin
            go_meta_q    <= go_meta_d;
            go_sync_q    <= go_sync_d;
            deb_cnt_q    <= deb_cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            wr_pulse_q   <= wr_pulse_d;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [9:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [ADDR_W:0]   count_q,     count_d;
    logic              full_pers_q, full_pers_d;
    logic              empty;
    logic              full;
    logic              wr_en;
    logic              pop_en;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_COUNT);
    // A write while full is dropped even when a pop lands in the same cycle.
    assign wr_en  = wr_pulse_q & ~full;
    assign pop_en = iPop & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        full_pers_d = full_pers_q | full;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({wr_en, pop_en})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_pers_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_pers_q <= full_pers_d;
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers and count
    // already makes every stale word unreachable, and a reset here would
    // prevent mapping onto RAM.
    always_ff @(posedge iClk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {iCmd, iD};
        end
    end

    // ------------------------------------------------------------------
    // Head word and command decode
    // ------------------------------------------------------------------
    always_comb begin
        oQ  = '0;
        oEq = '0;
        if (!empty) begin
            oQ           = mem[rd_ptr_q];
            oEq[oQ[3:0]] = 1'b1;
        end
    end

    assign oCmd            = oQ[9];
    assign oEmpty          = empty;
    assign oFull           = full;
    assign oFullPersistent = full_pers_q;
    assign oUsed           = count_q[ADDR_W-1:0];
    assign oWrPulse        = wr_pulse_q;

endmodule

// File: tb/tb_com_rx_frontend.sv
// -----------------------------------------------------------------------------
// tb_com_rx_frontend
//
// Directed, self-checking bench for com_rx_frontend with DEBOUNCE_CYCLES=4.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// at the same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_com_rx_frontend;

    localparam int DEB    = 4;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [8:0]        d   = '0;
    logic              cmd = 1'b0;
    logic              go  = 1'b0;
    logic              pop = 1'b0;
    logic [9:0]        q;
    logic              q_cmd;
    logic [15:0]       eq;
    logic              empty;
    logic              full;
    logic              full_pers;
    logic [ADDR_W-1:0] used;
    logic              wr_pulse;

    int n_cmp  = 0;
    int n_fail = 0;

    com_rx_frontend #(
        .DEBOUNCE_CYCLES(DEB),
        .ADDR_W         (ADDR_W)
    ) dut (
        .iClk           (clk),
        .iRst           (rst),
        .iD             (d),
        .iCmd           (cmd),
        .iGo            (go),
        .iPop           (pop),
        .oQ             (q),
        .oCmd           (q_cmd),
        .oEq            (eq),
        .oEmpty         (empty),
        .oFull          (full),
        .oFullPersistent(full_pers),
        .oUsed          (used),
        .oWrPulse       (wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise go, wait for the debounced pulse, let the write edge pass, then
    // drop go and wait long enough for the stable level to fall again.
    task automatic write_word(input logic [9:0] w, input bit pop_with_write);
        bit seen;
        seen = 1'b0;
        cmd  = w[9];
        d    = w[8:0];
        go   = 1'b1;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (wr_pulse) seen = 1'b1;
        end
        check("wr_pulse_seen", 32'(seen), 32'd1);
        if (pop_with_write) pop = 1'b1;
        tick();
        pop = 1'b0;
        go  = 1'b0;
        repeat (DEB + 6) tick();
    endtask

    task automatic pop_word();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    typedef struct {
        logic [9:0]  wdata;
        logic [9:0]  exp_q;
        logic        exp_cmd;
        logic [15:0] exp_eq;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int first_k;
        int pulses;

        vecs[0] = '{wdata: 10'h201, exp_q: 10'h201, exp_cmd: 1'b1, exp_eq: 16'h0002};
        vecs[1] = '{wdata: 10'h0A5, exp_q: 10'h0A5, exp_cmd: 1'b0, exp_eq: 16'h0020};
        vecs[2] = '{wdata: 10'h205, exp_q: 10'h205, exp_cmd: 1'b1, exp_eq: 16'h0020};
        vecs[3] = '{wdata: 10'h00C, exp_q: 10'h00C, exp_cmd: 1'b0, exp_eq: 16'h1000};
        vecs[4] = '{wdata: 10'h3F0, exp_q: 10'h3F0, exp_cmd: 1'b1, exp_eq: 16'h0001};

        // ---- Reset with go held high, then release and time the pulse ----
        go  = 1'b1;
        d   = 9'h1A5;
        cmd = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_full",      32'(full),      32'd0);
        check("rst_full_pers", 32'(full_pers), 32'd0);
        check("rst_used",      32'(used),      32'd0);
        check("rst_wr_pulse",  32'(wr_pulse),  32'd0);
        check("rst_q",         32'(q),         32'd0);
        check("rst_eq",        32'(eq),        32'd0);

        @(negedge clk);
        rst     = 1'b0;
        first_k = -1;
        pulses  = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (wr_pulse) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        check("go_latency_edges", 32'(first_k), 32'(DEB + 3));
        check("go_held_pulses",   32'(pulses),  32'd1);
        check("held_used",        32'(used),    32'd1);
        check("held_q",           32'(q),       32'h1A5);
        check("held_cmd",         32'(q_cmd),   32'd0);
        check("held_eq",          32'(eq),      32'h0020);
        go = 1'b0;
        repeat (DEB + 6) tick();
        pop_word();
        check("held_drained_empty", 32'(empty), 32'd1);

        // ---- Glitch train: go toggles every cycle ----
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            go = ~go;
            tick();
            if (wr_pulse) pulses++;
        end
        go = 1'b0;
        repeat (DEB + 6) begin
            tick();
            if (wr_pulse) pulses++;
        end
        check("glitch_pulses", 32'(pulses), 32'd0);
        check("glitch_empty",  32'(empty),  32'd1);

        // ---- Table-driven show-ahead and decode ----
        for (int i = 0; i < 5; i++) write_word(vecs[i].wdata, 1'b0);
        check("tbl_used", 32'(used), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("tbl_q[%0d]", i),     32'(q),     32'(vecs[i].exp_q));
            check($sformatf("tbl_cmd[%0d]", i),   32'(q_cmd), 32'(vecs[i].exp_cmd));
            check($sformatf("tbl_eq[%0d]", i),    32'(eq),    32'(vecs[i].exp_eq));
            check($sformatf("tbl_empty[%0d]", i), 32'(empty), 32'd0);
            pop_word();
        end
        check("tbl_end_empty", 32'(empty), 32'd1);
        check("tbl_end_q",     32'(q),     32'd0);
        check("tbl_end_eq",    32'(eq),    32'd0);

        // ---- Simultaneous pop and write with five words stored ----
        for (int i = 0; i < 5; i++) write_word(10'(10'h100 + i), 1'b0);
        check("sim_pre_used", 32'(used), 32'd5);
        check("sim_pre_q",    32'(q),    32'h100);
        write_word(10'h055, 1'b1);
        check("sim_used", 32'(used), 32'd5);
        check("sim_q",    32'(q),    32'h101);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("sim_drain_q[%0d]", i), 32'(q), 32'(10'h100 + i));
            pop_word();
        end
        check("sim_last_q", 32'(q), 32'h055);
        pop_word();
        check("sim_end_empty", 32'(empty), 32'd1);
        pop_word();
        check("pop_empty_used",  32'(used),  32'd0);
        check("pop_empty_empty", 32'(empty), 32'd1);
        check("pop_empty_q",     32'(q),     32'd0);

        // ---- Fill to full, dropped write, then drain ----
        for (int i = 0; i < DEPTH; i++) write_word(10'(i), 1'b0);
        check("fill_full",      32'(full),      32'd1);
        check("fill_used",      32'(used),      32'd0);
        check("fill_full_pers", 32'(full_pers), 32'd1);
        check("fill_empty",     32'(empty),     32'd0);
        write_word(10'h3FF, 1'b0);
        check("drop_full", 32'(full), 32'd1);
        check("drop_used", 32'(used), 32'd0);
        check("drop_q",    32'(q),    32'd0);
        pop_word();
        check("pop_full_full",      32'(full),      32'd0);
        check("pop_full_used",      32'(used),      32'(DEPTH - 1));
        check("pop_full_full_pers", 32'(full_pers), 32'd1);
        for (int i = 1; i < DEPTH; i++) begin
            check($sformatf("drain_q[%0d]", i), 32'(q), 32'(i));
            pop_word();
        end
        check("drain_empty",     32'(empty),     32'd1);
        check("drain_full_pers", 32'(full_pers), 32'd1);

        // ---- Async reset mid-debounce with seven words stored ----
        for (int i = 0; i < 7; i++) write_word(10'(10'h2C0 + i), 1'b0);
        check("pre_rst_used", 32'(used), 32'd7);
        go = 1'b1;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_empty",     32'(empty),     32'd1);
        check("mid_rst_used",      32'(used),      32'd0);
        check("mid_rst_full_pers", 32'(full_pers), 32'd0);
        check("mid_rst_q",         32'(q),         32'd0);
        go = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (wr_pulse) pulses++;
        end
        check("post_rst_pulses", 32'(pulses), 32'd0);
        check("post_rst_empty",  32'(empty),  32'd1);
        check("post_rst_used",   32'(used),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/com_rx_frontend.md
Name: com_rx_frontend

Overview:
- Receive front end of the MCU-to-draw communication path.
- Debounces the MCU go strobe into a single-cycle write pulse.
- Pushes the 10-bit word {iCmd, iD} into a show-ahead FIFO.
- Presents the FIFO head word with a one-hot decode of its low command nibble for the downstream command controller.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive synchronized samples required before the debounced go level changes (legal range 1..65535).
- ADDR_W, 10: FIFO address width; depth = 2**ADDR_W words (1024).

Ports:
- iClk  in  1  system clock, rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iD  in  9  MCU data; must be held stable while iGo is high.
- iCmd  in  1  MCU command flag; stored as bit 9.
- iGo  in  1  MCU go strobe; asynchronous and bouncy.
- iPop  in  1  read request; consumes the head word.
- oQ  out  10  head word {cmd, data}, show-ahead.
- oCmd  out  1  oQ[9].
- oEq  out  16  one-hot decode: oEq[k] = (oQ[3:0] == k).
- oEmpty  out  1  FIFO empty.
- oFull  out  1  FIFO full.
- oFullPersistent  out  1  sticky full flag.
- oUsed  out  ADDR_W  word count, modulo 2**ADDR_W.
- oWrPulse  out  1  debounced go pulse (the FIFO write strobe).

Behaviour:
- Reset (async, iRst=1), all outputs forced until release:
  - oEmpty=1, oFull=0, oFullPersistent=0, oUsed=0, oWrPulse=0, oQ=0, oEq=0.
  - Pointers and counters cleared; debounce synchronizer, counter and stable level cleared to 0.
  - RAM contents are not reset.
  - Reset mid-operation discards all stored words.
- Debounce:
  - Two-flop synchronizer on iGo.
  - A counter increments while the synchronized value differs from the stable level; it clears when they match.
  - When the count reaches DEBOUNCE_CYCLES, the stable level takes the synchronized value and the counter clears.
  - oWrPulse is high for exactly one cycle, in the cycle after the stable level goes 0->1.
  - A clean iGo rise produces the pulse DEBOUNCE_CYCLES+3 clock edges after the first edge that samples iGo=1.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no pulse.
  - The falling stable edge produces no pulse.
  - Holding iGo high indefinitely yields one pulse.
- Write:
  - On the oWrPulse cycle, {iCmd, iD} is sampled into RAM at the write pointer.
  - The write is accepted only if oFull=0. A write while full is dropped, even if iPop is asserted in the same cycle.
- Read:
  - iPop advances the read pointer only if oEmpty=0. Pop while empty is ignored.
- Show-ahead:
  - oQ = RAM[read pointer] whenever oEmpty=0, combinationally after the pointer update.
  - oQ = 0 while oEmpty=1.
  - A word written at edge N appears on oQ and deasserts oEmpty after edge N (one-cycle latency).
- Count:
  - Internal count is ADDR_W+1 bits.
  - Accepted write alone: +1. Accepted pop alone: -1. Both in one cycle: unchanged, and both pointers advance.
  - oEmpty = (count==0). oFull = (count==2**ADDR_W).
  - oUsed = count[ADDR_W-1:0], so it reads 0 when full (wrap), matching the legacy usedw convention.
- Pointers wrap modulo 2**ADDR_W.
- oFullPersistent is set on any cycle with oFull=1 and cleared only by iRst.
- Decode:
  - oCmd = oQ[9]; oEq[k] = (oQ[3:0]==k) for k=0..15. Exactly one bit is set when non-empty; oEq=0 when empty.
  - Protocol mapping: 0 flip, 1 polyline, 4 color, 5 dot; 2, 3 and 6..15 are decoded but unused downstream.
- All state is registered on iClk. The only combinational outputs are oQ, oCmd and oEq from RAM/pointers.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset with iGo=1 held: outputs at reset values; after release, exactly one oWrPulse at the specified latency; oUsed=1, oQ={iCmd, iD}.
- iGo toggled 1,0,1,0 each cycle for 20 cycles -> no oWrPulse, oEmpty stays 1.
- Write three words 0x201, 0x0A5, 0x205:
  - Before any pop: oQ=0x201, oCmd=1, oEq=16'h0002.
  - After 1st pop: oQ=0x0A5, oEq=16'h0020.
  - After 2nd pop: oQ=0x205, oEq=16'h0020, oCmd=1.
  - After 3rd pop: oEmpty=1, oQ=0, oEq=0.
- Fill with 1024 writes (force oWrPulse via repeated go) -> oFull=1, oUsed=0, oFullPersistent=1. 1025th write dropped; pop then shows word 0; after pop oFull=0, oUsed=1023, oFullPersistent stays 1.
- Simultaneous pop and write pulse with oUsed=5 -> oUsed stays 5, head advances. Pop on empty -> no change, oUsed stays 0.
- Assert iRst asynchronously mid-debounce with oUsed=7 -> immediate oEmpty=1, oUsed=0, oFullPersistent=0, no pending pulse after release.
